// File: rtl/pea_cfg_sequencer.sv
// Configuration sequencer: streams PE words into a shadow bank, commits to the active bank on an idle swap.
// Optional word legality check and shadow poisoning are enabled by defining PEA_CFG_OPCHECK_EN.
module pea_cfg_sequencer #(
  parameter int N_PE  = 16,
  parameter int CFG_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CFG_W-1:0]      cfg_data_i,
  input  logic                  cfg_clear_i,
  input  logic                  swap_req_i,
  input  logic                  pea_busy_i,
  output logic [N_PE*CFG_W-1:0] pe_cfg_o,
  output logic                  cfg_active_valid_o,
  output logic                  shadow_full_o,
  output logic                  swap_done_o,
  output logic                  cfg_err_o
);

  localparam int PTR_W = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_PE - 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [PTR_W-1:0]             ptr;
  logic [N_PE-1:0][CFG_W-1:0]   shadow;
  logic [N_PE-1:0][CFG_W-1:0]   active;
  logic                         active_valid;
  logic                         swap_done;
  logic                         accept;
  logic                         commit;
  logic                         poisoned;

  // Ready is a pure function of state and reset so no valid->ready loop can form upstream.
  assign cfg_ready_o        = (state == LOAD) && !rst_i;
  assign shadow_full_o      = (state == FULL);
  assign pe_cfg_o           = active;
  assign cfg_active_valid_o = active_valid;
  assign swap_done_o        = swap_done;

`ifdef PEA_CFG_OPCHECK_EN
  logic illegal;
  logic poison;
  logic err;

  assign illegal = (cfg_data_i[7:4] > 4'd8) || (cfg_data_i[11:8] > 4'd8) ||
                   (cfg_data_i[14:12] > 3'd6);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poison <= 1'b0;
      err    <= 1'b0;
    end else if (cfg_clear_i) begin
      poison <= 1'b0;
      err    <= 1'b0;
    end else if (accept && illegal) begin
      poison <= 1'b1;
      err    <= 1'b1;
    end
  end

  assign poisoned  = poison;
  assign cfg_err_o = err;
`else
  assign poisoned  = 1'b0;
  assign cfg_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= LOAD;
    else       state <= state_next;
  end

  // Clear outranks both a word accept and a commit.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      LOAD: begin
        accept = cfg_valid_i && !cfg_clear_i;
        if (accept && (ptr == LAST_PTR)) state_next = FULL;
      end
      FULL: begin
        commit = swap_req_i && !pea_busy_i && !cfg_clear_i && !poisoned;
        if (commit) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
    if (cfg_clear_i) state_next = LOAD;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr          <= '0;
      shadow       <= '0;
      active       <= '0;
      active_valid <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= commit;
      if (cfg_clear_i) begin
        ptr <= '0;
      end else if (accept) begin
        shadow[ptr] <= cfg_data_i;
        ptr         <= (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
      end
      if (commit) begin
        active       <= shadow;
        active_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pea_cfg_sequencer.sv
// Self-checking bench for pea_cfg_sequencer: scoreboard of expected active banks plus a control-vector table.
// Opcode-check expectations follow PEA_CFG_OPCHECK_EN.
module tb_pea_cfg_sequencer;
  localparam int N_PE  = 16;
  localparam int CFG_W = 32;
  localparam int BW    = N_PE * CFG_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CFG_W-1:0]  cfg_data;
  logic              cfg_clear;
  logic              swap_req;
  logic              pea_busy;
  logic [BW-1:0]     pe_cfg;
  logic              active_valid;
  logic              shadow_full;
  logic              swap_done;
  logic              cfg_err;

  int checks = 0;
  int fails  = 0;
  logic [BW-1:0] model_active;
  logic [BW-1:0] sb[$];

  typedef struct {
    logic swap;
    logic busy;
    logic clr;
    logic exp_done;
    logic exp_full;
    logic exp_ready;
  } vec_t;
  vec_t vecs[4];

  pea_cfg_sequencer #(.N_PE(N_PE), .CFG_W(CFG_W)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cfg_valid_i        (cfg_valid),
    .cfg_ready_o        (cfg_ready),
    .cfg_data_i         (cfg_data),
    .cfg_clear_i        (cfg_clear),
    .swap_req_i         (swap_req),
    .pea_busy_i         (pea_busy),
    .pe_cfg_o           (pe_cfg),
    .cfg_active_valid_o (active_valid),
    .shadow_full_o      (shadow_full),
    .swap_done_o        (swap_done),
    .cfg_err_o          (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Streams count words base+i (optional random gaps, optional illegal word); a full bank goes to the scoreboard.
  task automatic apply_stimulus(input logic [CFG_W-1:0] base, input int count, input bit gaps, input int bad_idx);
    logic [BW-1:0] bank = '0;
    logic [CFG_W-1:0] w;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      w = base + CFG_W'(i);
      if (i == bad_idx) w[7:4] = 4'd9;
      bank[i*CFG_W +: CFG_W] = w;
      cfg_valid = 1'b1;
      cfg_data  = w;
      if (i == 0) check_bit("ready_before_load", cfg_ready, 1'b1);
      tick();
    end
    cfg_valid = 1'b0;
    if (count == N_PE) begin
      sb.push_back(bank);
      check_bit("full_after_load", shadow_full, 1'b1);
      check_bit("ready_low_when_full", cfg_ready, 1'b0);
    end
  endtask

  task automatic check_output(input string name);
    check_bank({name, "_active"}, pe_cfg, model_active);
    check_bit({name, "_done"}, swap_done, 1'b0);
  endtask

  task automatic do_swap();
    swap_req  = 1'b1;
    pea_busy  = 1'b0;
    cfg_clear = 1'b0;
    tick();
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      model_active = sb.pop_front();
    end
    check_bit("swap_done_pulse", swap_done, 1'b1);
    check_bit("active_valid_set", active_valid, 1'b1);
    check_bit("ready_after_commit", cfg_ready, 1'b1);
    check_bank("commit_bank", pe_cfg, model_active);
    swap_req = 1'b0;
    tick();
    check_bit("swap_done_one_cycle", swap_done, 1'b0);
  endtask

  initial begin
    vecs[0] = '{swap: 1'b1, busy: 1'b1, clr: 1'b0, exp_done: 1'b0, exp_full: 1'b1, exp_ready: 1'b0};
    vecs[1] = '{swap: 1'b0, busy: 1'b0, clr: 1'b0, exp_done: 1'b0, exp_full: 1'b1, exp_ready: 1'b0};
    vecs[2] = '{swap: 1'b1, busy: 1'b0, clr: 1'b1, exp_done: 1'b0, exp_full: 1'b0, exp_ready: 1'b1};
    vecs[3] = '{swap: 1'b1, busy: 1'b0, clr: 1'b0, exp_done: 1'b0, exp_full: 1'b0, exp_ready: 1'b1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_clear = 1'b0;
    swap_req = 1'b0; pea_busy = 1'b0; model_active = '0;

    repeat (3) tick();
    check_bit("ready_in_reset", cfg_ready, 1'b0);
    check_bank("reset_active", pe_cfg, '0);
    check_bit("reset_active_valid", active_valid, 1'b0);
    check_bit("reset_full", shadow_full, 1'b0);
    check_bit("reset_done", swap_done, 1'b0);
    check_bit("reset_err", cfg_err, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("ready_after_reset", cfg_ready, 1'b1);

    $display("[TB] full load and busy-held swap");
    apply_stimulus(32'h0000_1000, N_PE, 1'b0, -1);
    swap_req = 1'b1;
    pea_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_output("busy_hold");
    end
    pea_busy = 1'b0;
    tick();
    if (sb.size() != 0) model_active = sb.pop_front();
    check_bit("busy_drop_done", swap_done, 1'b1);
    check_bank("busy_drop_bank", pe_cfg, model_active);
    check_bit("busy_drop_valid", active_valid, 1'b1);
    check_bit("busy_drop_ready", cfg_ready, 1'b1);
    swap_req = 1'b0;
    tick();
    check_bit("busy_drop_done_cleared", swap_done, 1'b0);

    $display("[TB] backpressure load, swap ignored in LOAD");
    swap_req = 1'b1;
    apply_stimulus(32'h0000_2000, N_PE, 1'b1, -1);
    check_output("second_load_old_bank");
    do_swap();

    $display("[TB] clear after 7 words");
    apply_stimulus(32'h0000_3000, 7, 1'b0, -1);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    check_bit("clear_full", shadow_full, 1'b0);
    check_bit("clear_ready", cfg_ready, 1'b1);
    check_bit("clear_keeps_valid", active_valid, 1'b1);
    check_output("clear_keeps_bank");
    apply_stimulus(32'h0000_4000, N_PE, 1'b0, -1);
    do_swap();

    $display("[TB] control vector table in FULL");
    apply_stimulus(32'h0000_5000, N_PE, 1'b0, -1);
    foreach (vecs[k]) begin
      swap_req  = vecs[k].swap;
      pea_busy  = vecs[k].busy;
      cfg_clear = vecs[k].clr;
      tick();
      if (vecs[k].clr) sb.delete();
      check_bit($sformatf("vec%0d_done", k), swap_done, vecs[k].exp_done);
      check_bit($sformatf("vec%0d_full", k), shadow_full, vecs[k].exp_full);
      check_bit($sformatf("vec%0d_ready", k), cfg_ready, vecs[k].exp_ready);
      check_bank($sformatf("vec%0d_bank", k), pe_cfg, model_active);
    end
    swap_req = 1'b0; pea_busy = 1'b0; cfg_clear = 1'b0;

    $display("[TB] opcode check load");
    apply_stimulus(32'h0000_6000, N_PE, 1'b0, 3);
`ifdef PEA_CFG_OPCHECK_EN
    check_bit("opcheck_err_set", cfg_err, 1'b1);
    swap_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_output("poison_refused");
    end
    swap_req  = 1'b0;
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    sb.delete();
    check_bit("opcheck_err_cleared", cfg_err, 1'b0);
    check_bit("opcheck_ready_after_clear", cfg_ready, 1'b1);
`else
    check_bit("no_opcheck_err", cfg_err, 1'b0);
    do_swap();
    check_bit("no_opcheck_err_after", cfg_err, 1'b0);
`endif

    $display("[TB] reset mid-load");
    apply_stimulus(32'h0000_7000, 10, 1'b0, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    model_active = '0;
    check_bank("midreset_bank", pe_cfg, model_active);
    check_bit("midreset_valid", active_valid, 1'b0);
    check_bit("midreset_full", shadow_full, 1'b0);
    check_bit("midreset_ready", cfg_ready, 1'b1);
    apply_stimulus(32'h0000_8000, N_PE, 1'b0, -1);
    do_swap();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pea_cfg_sequencer.md
# pea_cfg_sequencer

Configuration sequencer for the M×N processing element array. It accepts a stream of 32-bit PE configuration words over a valid/ready handshake and fills a shadow bank in PE order. On a swap request at a kernel boundary, with the array idle, it commits the whole shadow bank to the active bank in one cycle. The active bank drives the per-PE configuration registers, so the PEA always runs on a complete, coherent configuration.

## Interface
- N_PE, 16, number of PEs (M·N); one configuration word per PE (N_CFG_REGS_PE = 1)
- CFG_W, 32, configuration word width (N_CFG_BITS_PE)
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  configuration word valid
- cfg_ready_o  out  1  sequencer can accept a word
- cfg_data_i  in  CFG_W  configuration word for PE index = current write pointer
- cfg_clear_i  in  1  discard the partial or full shadow bank
- swap_req_i  in  1  level request to commit shadow to active
- pea_busy_i  in  1  PEA executing; a swap is forbidden while high
- pe_cfg_o  out  N_PE·CFG_W  active bank; PE i at bits [i·CFG_W +: CFG_W]
- cfg_active_valid_o  out  1  active bank holds a committed configuration
- shadow_full_o  out  1  all N_PE shadow words written
- swap_done_o  out  1  one-cycle pulse after a commit
- cfg_err_o  out  1  sticky illegal-word flag (see Configuration)

## Operation
- State machine with two states.
  - LOAD: cfg_ready_o=1. On valid&ready, write cfg_data_i into shadow[ptr] and increment ptr. When the accepted word is at ptr=N_PE-1, go to FULL and reset ptr to 0.
  - FULL: cfg_ready_o=0 and shadow_full_o=1.
- Commit rule: in FULL, on a cycle with swap_req_i=1, pea_busy_i=0, cfg_clear_i=0 and the shadow not poisoned, the following happen at the clock edge:
  - active ← shadow
  - cfg_active_valid_o ← 1
  - swap_done_o ← 1 for exactly one cycle
  - state ← LOAD
- swap_req_i in LOAD is ignored. No request is latched; the requester holds the level until it sees swap_done_o.
- cfg_clear_i has priority over a word accept and over a commit. It sets ptr←0, state←LOAD, clears poison and cfg_err_o, and leaves the active bank and cfg_active_valid_o unchanged.
- The shadow contents are never visible on pe_cfg_o until a commit.
- Word layout used for checking:
  - [3:0] fu_instr_t
  - [7:4] operand A pe_mux_sel_t, legal 0..8
  - [11:8] operand B pe_mux_sel_t, legal 0..8
  - [14:12] delay_pe_mux_sel_t, legal 0..6
  - remaining bits are passed through unchecked

## Timing
- Reset values:
  - pe_cfg_o all zero (every PE NOP, inputs STREAM_IN0)
  - cfg_active_valid_o=0, shadow_full_o=0, swap_done_o=0, cfg_err_o=0
  - ptr=0, state LOAD
  - cfg_ready_o=0 while rst_i=1, then 1 in the first cycle after reset
- cfg_ready_o depends only on state and rst_i; it has no combinational path from cfg_valid_i.
- Throughput is one word per cycle. Minimum time from the first word to a possible commit is N_PE cycles plus 1 (the FULL cycle).
- Commit latency: pe_cfg_o, cfg_active_valid_o and swap_done_o change in the cycle after the qualifying cycle. The next word can be accepted in that same cycle.
- Reset mid-load or mid-commit wins unconditionally. Every register returns to its reset value and the active bank returns to all zero.

## Configuration
- PEA_CFG_OPCHECK_EN defined:
  - Each accepted word is checked against the legal ranges above.
  - An illegal word is still accepted, and ptr advances.
  - The word sets sticky cfg_err_o the next cycle and poisons the shadow bank.
  - A poisoned FULL shadow never commits; only cfg_clear_i or reset recovers.
- PEA_CFG_OPCHECK_EN undefined:
  - No check is performed, no poison logic exists, and cfg_err_o is tied to 0.

## Test plan
- Reset: assert rst_i for 3 cycles → all outputs at their reset values, cfg_ready_o=0 during reset and 1 on the first cycle after.
- Full load and swap:
  - Stimulus: stream words 0x0000_1000+i (i=0..15) back-to-back, then hold swap_req_i=1 with pea_busy_i=1 for 5 cycles, then drop pea_busy_i.
  - Response: cfg_ready_o falls after word 15 and shadow_full_o=1. pe_cfg_o does not change while busy. One cycle after busy drops, slice i = 0x1000+i, swap_done_o pulses for 1 cycle, cfg_active_valid_o=1, cfg_ready_o=1.
- Backpressure and ordering:
  - Stimulus: random gaps on cfg_valid_i, and a second load while the first configuration is active.
  - Response: word order is preserved, and the active bank stays at the old values until the second commit.
- Clear:
  - Stimulus: assert cfg_clear_i after 7 words, then load 16 new words. Separately, assert cfg_clear_i together with a qualifying swap in FULL.
  - Response: the new words land at indices 0..15. In the simultaneous case no commit occurs, swap_done_o stays 0 and the active bank is unchanged.
- Opcode check:
  - Stimulus with PEA_CFG_OPCHECK_EN: word 3 has bits [7:4]=9.
  - Response: cfg_err_o=1 and the swap is refused indefinitely; cfg_clear_i clears the error.
  - Stimulus without the macro: same load.
  - Response: the load commits normally and cfg_err_o stays 0.
- Reset mid-load: after 10 words, pulse rst_i for 1 cycle → ptr=0, active bank all zero, cfg_active_valid_o=0, and the next full load commits correctly.
